// File: rtl/tff_array_pkg.sv
// Shared constants and the ripple-carry toggle helper for the tff_array toggle bank.
package tff_array_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  localparam bit CASCADE_OFF = 1'b0;
  localparam bit CASCADE_ON  = 1'b1;

  typedef logic [MAX_WIDTH-1:0] tvec_t;

  // Bit i toggles only when every lower bit toggles and is currently 1, gated by t_req[i].
  function automatic tvec_t cascade_toggle(input tvec_t t_req, input tvec_t q);
    tvec_t t;
    t    = {MAX_WIDTH{1'b0}};
    t[0] = t_req[0];
    for (int i = 1; i < MAX_WIDTH; i++) begin
      t[i] = t_req[i] & t[i-1] & q[i-1];
    end
    return t;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One toggle bit: sync reset to INIT_BIT, optional load (TFF_ARRAY_LOAD_EN), enabled XOR toggle.
module tff_cell
  import tff_array_pkg::*;
#(
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic t_i,
`ifdef TFF_ARRAY_LOAD_EN
  input  logic ld_i,
  input  logic d_i,
`endif
  output logic q_o
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
`ifdef TFF_ARRAY_LOAD_EN
    if (ld_i) begin
      q_d = d_i;
    end else if (en_i) begin
      q_d = q_q ^ t_i;
    end else begin
      q_d = q_q;
    end
`else
    if (en_i) begin
      q_d = q_q ^ t_i;
    end else begin
      q_d = q_q;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= INIT_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tff_array.sv
// WIDTH-bit toggle flip-flop bank with optional ripple-carry cascade, carry-out and change flag.
// Load port behaviour is compiled in only when TFF_ARRAY_LOAD_EN is defined.
module tff_array
  import tff_array_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b0}},
  parameter bit               CASCADE = CASCADE_OFF
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic [WIDTH-1:0] T,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             CHG
);

  if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_width_check
    $error("tff_array: WIDTH must be in 1..%0d", MAX_WIDTH);
  end

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] t_s;
  logic             co_raw_s;
  logic             chg_d;
  logic             chg_q;

  always_comb begin
    t_s = T;
    if (CASCADE == CASCADE_ON) begin
      t_s = WIDTH'(cascade_toggle(MAX_WIDTH'(T), MAX_WIDTH'(q_s)));
    end else begin
      t_s = T;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .INIT_BIT (INIT[i])
    ) u_cell (
      .clk_i (C),
      .rst_i (R),
      .en_i  (E),
      .t_i   (t_s[i]),
`ifdef TFF_ARRAY_LOAD_EN
      .ld_i  (L),
      .d_i   (D[i]),
`endif
      .q_o   (q_s[i])
    );
  end

`ifndef TFF_ARRAY_LOAD_EN
  logic unused_load_s;
  assign unused_load_s = ^{L, D};
`endif

  // Cascade: carry out of the top bit. Independent: the next state is all ones.
  always_comb begin
    co_raw_s = 1'b0;
    if (CASCADE == CASCADE_ON) begin
      co_raw_s = E & t_s[WIDTH-1] & q_s[WIDTH-1];
    end else begin
      co_raw_s = E & (&(q_s ^ t_s));
    end
  end

`ifdef TFF_ARRAY_LOAD_EN
  assign CO = co_raw_s & ~R & ~L;
`else
  assign CO = co_raw_s & ~R;
`endif

  always_comb begin
    chg_d = 1'b0;
`ifdef TFF_ARRAY_LOAD_EN
    if (L) begin
      chg_d = (D != q_s);
    end else if (E) begin
      chg_d = |t_s;
    end else begin
      chg_d = 1'b0;
    end
`else
    if (E) begin
      chg_d = |t_s;
    end else begin
      chg_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge C) begin
    if (R) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign Q   = q_s;
  assign CHG = chg_q;

endmodule

// File: tb/tb_tff_array.sv
// Directed bench for tff_array: independent, cascade and single-bit instances.
module tb_tff_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       a_r, a_e, a_l, a_co, a_chg;
  logic [7:0] a_t, a_d, a_q;
  logic       b_r, b_e, b_l, b_co, b_chg;
  logic [7:0] b_t, b_d, b_q;
  logic       c_r, c_e, c_l, c_co, c_chg;
  logic [0:0] c_t, c_d, c_q;

  logic [7:0] exp_a;

  tff_array #(.WIDTH(8), .INIT(8'hA5), .CASCADE(1'b0)) dut_a (
    .C(clk), .R(a_r), .E(a_e), .T(a_t), .L(a_l), .D(a_d),
    .Q(a_q), .CO(a_co), .CHG(a_chg)
  );

  tff_array #(.WIDTH(8), .INIT(8'hFE), .CASCADE(1'b1)) dut_b (
    .C(clk), .R(b_r), .E(b_e), .T(b_t), .L(b_l), .D(b_d),
    .Q(b_q), .CO(b_co), .CHG(b_chg)
  );

  tff_array #(.WIDTH(1), .INIT(1'b0), .CASCADE(1'b1)) dut_c (
    .C(clk), .R(c_r), .E(c_e), .T(c_t), .L(c_l), .D(c_d),
    .Q(c_q), .CO(c_co), .CHG(c_chg)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_r = 1'b1; a_e = 1'b1; a_t = 8'hFF; a_l = 1'b0; a_d = 8'h00;
    b_r = 1'b1; b_e = 1'b1; b_t = 8'hFF; b_l = 1'b0; b_d = 8'h00;
    c_r = 1'b1; c_e = 1'b0; c_t = 1'b1; c_l = 1'b0; c_d = 1'b0;
    tick;
    tick;
    n_vec++; if (a_q !== 8'hA5) begin n_err++; $display("FAIL reset_q: got %h want a5", a_q); end
    n_vec++; if (a_chg !== 1'b0) begin n_err++; $display("FAIL reset_chg: got %b want 0", a_chg); end
    n_vec++; if (a_co !== 1'b0) begin n_err++; $display("FAIL reset_co: got %b want 0", a_co); end
    n_vec++; if (b_q !== 8'hFE) begin n_err++; $display("FAIL reset_b_q: got %h want fe", b_q); end
    n_vec++; if (b_co !== 1'b0) begin n_err++; $display("FAIL reset_b_co: got %b want 0", b_co); end
    n_vec++; if (c_q !== 1'b0) begin n_err++; $display("FAIL reset_c_q: got %b want 0", c_q); end
    a_r = 1'b0; b_r = 1'b0; b_e = 1'b0; c_r = 1'b0;
    tick;
    n_vec++; if (a_q !== 8'h5A) begin n_err++; $display("FAIL release_q: got %h want 5a", a_q); end
    n_vec++; if (a_chg !== 1'b1) begin n_err++; $display("FAIL release_chg: got %b want 1", a_chg); end
    n_vec++; if (b_q !== 8'hFE || b_chg !== 1'b0) begin n_err++; $display("FAIL release_b_hold: got %h/%b want fe/0", b_q, b_chg); end
  endtask

  task automatic test_independent;
    a_t = 8'h5A;
    tick;
    n_vec++; if (a_q !== 8'h00) begin n_err++; $display("FAIL indep_clear: got %h want 00", a_q); end
    a_t = 8'h0F;
    #1;
    n_vec++; if (a_co !== 1'b0) begin n_err++; $display("FAIL indep_co_0f: got %b want 0", a_co); end
    tick;
    n_vec++; if (a_q !== 8'h0F || a_chg !== 1'b1) begin n_err++; $display("FAIL indep_0f: got %h/%b want 0f/1", a_q, a_chg); end
    a_t = 8'hF0;
    #1;
    n_vec++; if (a_co !== 1'b1) begin n_err++; $display("FAIL indep_co_f0: got %b want 1", a_co); end
    tick;
    n_vec++; if (a_q !== 8'hFF || a_chg !== 1'b1) begin n_err++; $display("FAIL indep_ff: got %h/%b want ff/1", a_q, a_chg); end
    n_vec++; if (a_co !== 1'b0) begin n_err++; $display("FAIL indep_co_after: got %b want 0", a_co); end
    exp_a = 8'hFF;
  endtask

  task automatic test_counter_wrap;
    b_e = 1'b1; b_t = 8'hFF;
    #1;
    n_vec++; if (b_co !== 1'b0) begin n_err++; $display("FAIL wrap_co_fe: got %b want 0", b_co); end
    tick;
    n_vec++; if (b_q !== 8'hFF || b_chg !== 1'b1) begin n_err++; $display("FAIL wrap_ff: got %h/%b want ff/1", b_q, b_chg); end
    n_vec++; if (b_co !== 1'b1) begin n_err++; $display("FAIL wrap_co_ff: got %b want 1", b_co); end
    tick;
    n_vec++; if (b_q !== 8'h00 || b_chg !== 1'b1) begin n_err++; $display("FAIL wrap_00: got %h/%b want 00/1", b_q, b_chg); end
    n_vec++; if (b_co !== 1'b0) begin n_err++; $display("FAIL wrap_co_00: got %b want 0", b_co); end
  endtask

  task automatic test_cascade_gating;
    tick;
    tick;
    tick;
    n_vec++; if (b_q !== 8'h03) begin n_err++; $display("FAIL count_03: got %h want 03", b_q); end
    b_t = 8'hFD;
    #1;
    n_vec++; if (b_co !== 1'b0) begin n_err++; $display("FAIL gate_co: got %b want 0", b_co); end
    tick;
    n_vec++; if (b_q !== 8'h02 || b_chg !== 1'b1) begin n_err++; $display("FAIL gate_q: got %h/%b want 02/1", b_q, b_chg); end
  endtask

  task automatic test_reset_midcount;
    b_t = 8'hFF; b_e = 1'b1; b_l = 1'b1; b_d = 8'h55; b_r = 1'b1;
    #1;
    n_vec++; if (b_co !== 1'b0) begin n_err++; $display("FAIL midrst_co: got %b want 0", b_co); end
    tick;
    n_vec++; if (b_q !== 8'hFE || b_chg !== 1'b0) begin n_err++; $display("FAIL midrst_q: got %h/%b want fe/0", b_q, b_chg); end
    b_r = 1'b0; b_l = 1'b0;
    tick;
    n_vec++; if (b_q !== 8'hFF) begin n_err++; $display("FAIL midrst_resume: got %h want ff", b_q); end
  endtask

  task automatic test_load;
    logic       exp_co;
    logic       exp_chg;
    a_e = 1'b1; a_t = 8'hEF;
    tick;
    n_vec++; if (a_q !== 8'h10) begin n_err++; $display("FAIL load_setup: got %h want 10", a_q); end
    a_l = 1'b1; a_d = 8'h3C;
`ifdef TFF_ARRAY_LOAD_EN
    exp_co = 1'b0;
`else
    exp_co = 1'b1;
`endif
    #1;
    n_vec++; if (a_co !== exp_co) begin n_err++; $display("FAIL load_co_gate: got %b want %b", a_co, exp_co); end
    a_t = 8'hFF;
    #1;
    n_vec++; if (a_co !== 1'b0) begin n_err++; $display("FAIL load_co: got %b want 0", a_co); end
    tick;
`ifdef TFF_ARRAY_LOAD_EN
    exp_a = 8'h3C;
`else
    exp_a = 8'hEF;
`endif
    n_vec++; if (a_q !== exp_a || a_chg !== 1'b1) begin n_err++; $display("FAIL load_first: got %h/%b want %h/1", a_q, a_chg, exp_a); end
    tick;
`ifdef TFF_ARRAY_LOAD_EN
    exp_a = 8'h3C; exp_chg = 1'b0;
`else
    exp_a = 8'h10; exp_chg = 1'b1;
`endif
    n_vec++; if (a_q !== exp_a || a_chg !== exp_chg) begin n_err++; $display("FAIL load_same: got %h/%b want %h/%b", a_q, a_chg, exp_a, exp_chg); end
    a_l = 1'b0;
  endtask

  task automatic test_enable_low;
    a_e = 1'b0; a_t = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (a_co !== 1'b0) begin n_err++; $display("FAIL en_low_co[%0d]: got %b want 0", k, a_co); end
      tick;
      n_vec++; if (a_q !== exp_a || a_chg !== 1'b0) begin n_err++; $display("FAIL en_low_q[%0d]: got %h/%b want %h/0", k, a_q, a_chg, exp_a); end
    end
  endtask

  task automatic test_width1;
    c_e = 1'b1; c_t = 1'b1;
    #1;
    n_vec++; if (c_co !== 1'b0) begin n_err++; $display("FAIL w1_co0: got %b want 0", c_co); end
    tick;
    n_vec++; if (c_q !== 1'b1 || c_co !== 1'b1) begin n_err++; $display("FAIL w1_one: got %b/%b want 1/1", c_q, c_co); end
    tick;
    n_vec++; if (c_q !== 1'b0 || c_chg !== 1'b1) begin n_err++; $display("FAIL w1_wrap: got %b/%b want 0/1", c_q, c_chg); end
  endtask

  initial begin
    test_reset;
    test_independent;
    test_counter_wrap;
    test_cascade_gating;
    test_reset_midcount;
    test_load;
    test_enable_low;
    test_width1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
